// File: rtl/if_fetch_ctrl_if.sv
// Bundle of the fetch controller's load, redirect, PC and instruction-memory signals.
// The master side drives requests; the slave side is the fetch controller.
interface if_fetch_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              load_start;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              halt_req;
    logic              stall;
    logic              br_taken;
    logic              jr_req;
    logic              j_req;
    logic [31:0]       npc;
    logic [1:0]        pc_src;
    logic [31:0]       pc;
    logic              fetch_en;
    logic              flush;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_we;
    logic              load_done;
    logic [1:0]        state;

    modport master (
        output load_start, load_valid, load_data, load_last,
        output halt_req, stall, br_taken, jr_req, j_req, npc,
        input  load_ready, pc_src, pc, fetch_en, flush,
        input  imem_addr, imem_wdata, imem_we, load_done, state
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  halt_req, stall, br_taken, jr_req, j_req, npc,
        output load_ready, pc_src, pc, fetch_en, flush,
        output imem_addr, imem_wdata, imem_we, load_done, state
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, selects the next-PC source, applies
// stalls/flushes and boot-loads instruction memory before execution starts.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_W     = 5,
    parameter int          IMEM_DEPTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    if_fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(IMEM_DEPTH - 1);

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic word_accept;
    logic load_exit;
    logic any_redirect;

    assign word_accept  = (state_q == S_LOAD) && bus.load_valid;
    // The last slot of memory ends the load even without load_last, so the counter never wraps.
    assign load_exit    = word_accept && (bus.load_last || (cnt_q == CNT_MAX));
    assign any_redirect = (state_q == S_RUN) && (bus.br_taken || bus.jr_req || bus.j_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.load_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (load_exit) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                end else if (word_accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // A redirect wins over stall; halt still lets this cycle's PC update land.
                if (any_redirect || !bus.stall) begin
                    pc_d = bus.npc;
                end
                if (bus.halt_req) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready = 1'b0;
        bus.imem_we    = 1'b0;
        bus.imem_addr  = '0;
        bus.imem_wdata = '0;
        bus.load_done  = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.flush      = 1'b0;
        bus.pc_src     = 2'd0;
        case (state_q)
            S_LOAD: begin
                bus.load_ready = 1'b1;
                bus.imem_we    = bus.load_valid;
                bus.imem_addr  = cnt_q;
                bus.imem_wdata = bus.load_data;
                bus.load_done  = load_exit;
            end
            S_RUN: begin
                bus.fetch_en  = !bus.stall;
                bus.imem_addr = pc_q[ADDR_W+1:2];
                bus.flush     = any_redirect;
                if (bus.br_taken) begin
                    bus.pc_src = 2'd1;
                end else if (bus.jr_req) begin
                    bus.pc_src = 2'd2;
                end else if (bus.j_req) begin
                    bus.pc_src = 2'd3;
                end
            end
            default: ;
        endcase
    end

    assign bus.pc    = pc_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: scoreboarded memory writes and PC updates
// plus direct checks on the combinational fetch controls.
module tb_if_fetch_ctrl;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    if_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .ADDR_W    (ADDR_W),
        .IMEM_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] pc_exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_pc = 32'h0;
    int          model_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every memory write the DUT issues must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", {27'd0, bus.imem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("wr_addr", {27'd0, bus.imem_addr}, {27'd0, w.addr});
                check("wr_data", bus.imem_wdata, w.data);
                $display("write addr=%0d data=%h", bus.imem_addr, bus.imem_wdata);
            end
        end
    end

    task automatic clear_inputs();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 32'h0;
        bus.load_last  = 1'b0;
        bus.halt_req   = 1'b0;
        bus.stall      = 1'b0;
        bus.br_taken   = 1'b0;
        bus.jr_req     = 1'b0;
        bus.j_req      = 1'b0;
        bus.npc        = 32'h0;
    endtask

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        next_cycle();
        bus.load_start = 1'b0;
        model_cnt = 0;
        check("state_load", {30'd0, bus.state}, 32'd1);
        check("load_ready", {31'd0, bus.load_ready}, 32'd1);
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        wr_t w;
        logic exit_exp;
        exit_exp = last || (model_cnt == DEPTH - 1);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        w.addr = ADDR_W'(model_cnt);
        w.data = data;
        wr_q.push_back(w);
        #3;
        check("load_done", {31'd0, bus.load_done}, {31'd0, exit_exp});
        next_cycle();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        model_cnt = exit_exp ? 0 : model_cnt + 1;
        if (exit_exp) begin
            model_pc = 32'h0;
            check("state_run", {30'd0, bus.state}, 32'd2);
            check("pc_run_entry", bus.pc, 32'h0);
            check("done_low", {31'd0, bus.load_done}, 32'd0);
        end
    endtask

    task automatic load_gap();
        #3;
        check("gap_we", {31'd0, bus.imem_we}, 32'd0);
        check("gap_addr", {27'd0, bus.imem_addr}, model_cnt);
        next_cycle();
    endtask

    task automatic run_cycle(input logic st, input logic br, input logic jr, input logic j,
                             input logic hlt, input logic [31:0] target);
        logic        redir;
        logic [1:0]  src;
        logic [31:0] nxt;
        redir = br || jr || j;
        src   = br ? 2'd1 : jr ? 2'd2 : j ? 2'd3 : 2'd0;
        nxt   = redir ? target : (st ? model_pc : model_pc + 32'd4);
        bus.stall    = st;
        bus.br_taken = br;
        bus.jr_req   = jr;
        bus.j_req    = j;
        bus.halt_req = hlt;
        bus.npc      = redir ? target : model_pc + 32'd4;
        pc_exp_q.push_back(nxt);
        #3;
        check("pc_now", bus.pc, model_pc);
        check("pc_src", {30'd0, bus.pc_src}, {30'd0, src});
        check("flush", {31'd0, bus.flush}, {31'd0, redir});
        check("fetch_en", {31'd0, bus.fetch_en}, {31'd0, !st});
        check("imem_addr_run", {27'd0, bus.imem_addr}, {27'd0, model_pc[ADDR_W+1:2]});
        next_cycle();
        model_pc = pc_exp_q.pop_front();
        check("pc_next", bus.pc, model_pc);
        $display("run st=%0b br=%0b jr=%0b j=%0b halt=%0b pc=%h", st, br, jr, j, hlt, bus.pc);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        #1;
        check("rst_state", {30'd0, bus.state}, 32'd0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_outs", {bus.pc_src, bus.fetch_en, bus.flush, bus.imem_we, bus.load_ready,
                           bus.load_done, bus.imem_addr, bus.imem_wdata[0]}, 32'd0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check("idle_state", {30'd0, bus.state}, 32'd0);

        // Three-word boot program.
        start_load();
        load_word(32'h2008_0005, 1'b0);
        load_gap();
        load_word(32'h2009_0003, 1'b0);
        load_word(32'h0109_5020, 1'b1);

        // Sequential fetch with a two-cycle stall.
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("pc_after_stall", bus.pc, 32'hC);

        // Redirect priority; redirect beats stall.
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100);

        // Halt together with a register jump: jump lands, then HALT.
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
        check("halt_state", {30'd0, bus.state}, 32'd3);
        bus.br_taken = 1'b1;
        bus.npc      = 32'h300;
        #3;
        check("halt_fetch", {31'd0, bus.fetch_en}, 32'd0);
        check("halt_flush", {31'd0, bus.flush}, 32'd0);
        check("halt_src", {30'd0, bus.pc_src}, 32'd0);
        next_cycle();
        clear_inputs();
        check("halt_pc", bus.pc, 32'h200);
        check("halt_stay", {30'd0, bus.state}, 32'd3);

        // Reload of a full memory without load_last.
        start_load();
        for (int i = 0; i < DEPTH; i++) begin
            load_word(32'hA000_0000 + i, 1'b0);
        end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset in the middle of a load.
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        start_load();
        load_word(32'h1111_1111, 1'b0);
        load_word(32'h2222_2222, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_state", {30'd0, bus.state}, 32'd0);
        check("arst_ready", {31'd0, bus.load_ready}, 32'd0);
        check("arst_pc", bus.pc, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEAD_BEEF;
        #3;
        check("idle_no_we", {31'd0, bus.imem_we}, 32'd0);
        next_cycle();
        check("idle_needs_start", {30'd0, bus.state}, 32'd0);
        clear_inputs();
        start_load();
        load_word(32'h3333_3333, 1'b1);

        next_cycle();
        check("wr_leftover", wr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage.
- Owns the PC register and arbitrates the four next-PC sources (sequential, branch, register jump, direct jump) into the 2-bit PC-source select driven to the IF next-PC mux.
- Applies hazard stalls and generates the IF/ID flush.
- Shares the instruction-memory write port between a boot-load FSM and normal fetch, so a program is written into instruction memory before execution starts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset and on every entry to RUN.
- ADDR_W, 5, instruction-memory word-address width.
- IMEM_DEPTH, 32, number of instruction-memory words; must equal 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse: begin a program load (ignored in LOAD)
- load_valid  in  1  load_data holds a valid word
- load_data  in  32  program word to write
- load_last  in  1  qualifies load_valid: this is the final word
- load_ready  out  1  controller accepts load words (high only in LOAD)
- halt_req  in  1  stop fetching (RUN only)
- stall  in  1  hazard-unit stall: hold PC
- br_taken  in  1  branch resolved taken (EX)
- jr_req  in  1  register jump (EX)
- j_req  in  1  direct jump (ID)
- npc  in  32  next PC from the IF mux
- pc_src  out  2  mux select: 0 = pc+4, 1 = branch, 2 = jr, 3 = jump
- pc  out  32  current PC register
- fetch_en  out  1  IF output valid this cycle
- flush  out  1  kill the instruction in IF/ID
- imem_addr  out  ADDR_W  instruction-memory address
- imem_wdata  out  32  instruction-memory write data
- imem_we  out  1  instruction-memory write enable
- load_done  out  1  one-cycle pulse when LOAD completes
- state  out  2  0 = IDLE, 1 = LOAD, 2 = RUN, 3 = HALT

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, pc = RESET_PC, load counter = 0.
  - All other outputs 0: pc_src, fetch_en, flush, imem_we, imem_wdata, imem_addr, load_ready, load_done.
  - Deassertion takes effect at the next clk edge.
  - Reset mid-LOAD abandons the load; words already written remain in memory.
- IDLE:
  - Fetch disabled; pc held.
  - load_start -> LOAD, counter cleared.
- LOAD:
  - load_ready = 1.
  - Combinational write: imem_we = load_valid, imem_addr = counter, imem_wdata = load_data.
  - Counter increments on each accepted word.
  - Exit to RUN when the accepted word has load_last = 1 or counter = IMEM_DEPTH-1; that word is written, and load_done pulses for one cycle at the RUN entry edge.
  - On RUN entry, pc = RESET_PC and the counter returns to 0.
  - load_start, halt_req and redirect inputs are ignored in LOAD.
- RUN:
  - fetch_en = !stall.
  - imem_we = 0, imem_addr = pc[ADDR_W+1:2].
  - pc_src priority: br_taken (1) > jr_req (2) > j_req (3) > sequential (0).
  - pc <= npc each cycle unless stall is high with no redirect.
  - Any redirect overrides stall: pc updates, and flush = 1 in the same cycle (combinational).
  - pc_src is combinational from the requests and is 0 outside RUN.
- halt_req in RUN:
  - -> HALT at the next edge.
  - A redirect in the same cycle is still taken; the PC update happens first.
- HALT:
  - pc frozen; fetch_en = 0, flush = 0.
  - load_start -> LOAD; nothing else exits except reset.
- Width rules:
  - pc is always 32 bits; no alignment check.
  - Counter wraps only via the exit rule and never exceeds IMEM_DEPTH-1.
- Latency:
  - Redirect visible on pc one cycle after the request.
  - First fetch (fetch_en = 1) in the cycle after load_done.

Test Plan:
- Reset/load: rst_n low; release; load_start; load three words 0x20080005, 0x20090003, 0x01095020 with load_last on the third -> imem_we pulses at addr 0, 1, 2 with matching data; load_done pulses once; state = RUN; pc = 0x0.
- Auto-exit: load 32 words without load_last -> exit to RUN after the addr-31 write; counter returns to 0; no write to addr 0 afterwards.
- Sequential fetch with stall: RUN, npc = pc+4; stall high cycles 3–4 -> pc goes 0x0, 0x4, 0x8, 0x8, 0x8, 0xC; fetch_en low during the stall; pc_src = 0 throughout.
- Simultaneous requests: br_taken, jr_req and j_req together, with stall high -> pc_src = 1, flush = 1, pc = npc (e.g. 0x40) next cycle. Then j_req alone -> pc_src = 3.
- Halt/reload: halt_req plus jr_req in the same cycle -> pc takes the jr target, state = HALT, fetch_en = 0. load_start -> LOAD; new load -> RUN with pc = RESET_PC.
- Reset mid-load: assert rst_n low after two words -> all outputs 0 immediately (asynchronous); state = IDLE; load_start is required to restart.
